wr_decode_pipe: RTL and testbench

WR_DECODE_PIPE -- requirements
Module: wr_decode_pipe

---
 rtl/wr_decode_pipe.sv | 93 +++++++++
 tb/tb_wr_decode_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wr_decode_pipe.sv
// Multi-port write-address decoder with lowest-port-wins arbitration,
// one registered stage, and a saturating same-address conflict counter.
module wr_decode_pipe #(
    parameter  int ADDR_W      = 5,
    parameter  int NPORT       = 2,
    parameter  int ZERO_IDX_EN = 1,
    parameter  int CNT_W       = 8,
    localparam int NSEL        = 2 ** ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NPORT-1:0]        req_valid,
    input  logic [NPORT*ADDR_W-1:0] req_addr,
    input  logic                    stall,
    input  logic                    clr_cnt,
    output logic [NSEL-1:0]         wr_en,
    output logic [NPORT*NSEL-1:0]   wr_port,
    output logic                    out_valid,
    output logic                    conflict,
    output logic [CNT_W-1:0]        conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = {ADDR_W{1'b1}};
    localparam logic [NSEL-1:0]   ONE_HOT0 = {{(NSEL-1){1'b0}}, 1'b1};

    logic [NPORT-1:0]      live;
    logic [NPORT-1:0]      grant;
    logic [NPORT*NSEL-1:0] port_next;
    logic [NSEL-1:0]       en_next;
    logic                  conflict_next;

    // A port is live when it requests and does not target the hard-wired zero index.
    genvar gi;
    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_live
            assign live[gi] = req_valid[gi] &&
                              !((ZERO_IDX_EN != 0) && (req_addr[gi*ADDR_W +: ADDR_W] == ZERO_IDX));
        end
    endgenerate

    // Any live lower port on the same address wins; every such pair is a conflict.
    always_comb begin
        grant         = live;
        conflict_next = 1'b0;
        for (int p = 1; p < NPORT; p++) begin
            for (int q = 0; q < p; q++) begin
                if (live[p] && live[q] &&
                    (req_addr[p*ADDR_W +: ADDR_W] == req_addr[q*ADDR_W +: ADDR_W])) begin
                    grant[p]      = 1'b0;
                    conflict_next = 1'b1;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_decode
            assign port_next[gi*NSEL +: NSEL] =
                grant[gi] ? (ONE_HOT0 << req_addr[gi*ADDR_W +: ADDR_W]) : '0;
        end
    endgenerate

    always_comb begin
        en_next = '0;
        for (int p = 0; p < NPORT; p++) begin
            en_next = en_next | port_next[p*NSEL +: NSEL];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en        <= '0;
            wr_port      <= '0;
            out_valid    <= 1'b0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            if (!stall) begin
                wr_en     <= en_next;
                wr_port   <= port_next;
                out_valid <= |en_next;
                conflict  <= conflict_next;
            end
            // Clear works through a stall; stall only blocks counting.
            if (clr_cnt) begin
                conflict_cnt <= '0;
            end else if (!stall && conflict_next && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wr_decode_pipe.sv
// Directed-vector bench for wr_decode_pipe (3 ports, 2-bit counter); expectations
// are queued at issue time and checked by an independent monitor.
module tb_wr_decode_pipe;

    localparam int ADDR_W = 5;
    localparam int NPORT  = 3;
    localparam int CNT_W  = 2;
    localparam int NSEL   = 32;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [NPORT-1:0]        req_valid;
    logic [NPORT*ADDR_W-1:0] req_addr;
    logic                    stall;
    logic                    clr_cnt;
    logic [NSEL-1:0]         wr_en;
    logic [NPORT*NSEL-1:0]   wr_port;
    logic                    out_valid;
    logic                    conflict;
    logic [CNT_W-1:0]        conflict_cnt;

    typedef struct {
        logic [NSEL-1:0]       wr_en;
        logic [NPORT*NSEL-1:0] wr_port;
        logic                  out_valid;
        logic                  conflict;
        logic [CNT_W-1:0]      cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    wr_decode_pipe #(
        .ADDR_W(ADDR_W), .NPORT(NPORT), .ZERO_IDX_EN(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .stall(stall), .clr_cnt(clr_cnt), .wr_en(wr_en), .wr_port(wr_port),
        .out_valid(out_valid), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NPORT*NSEL-1:0] act,
                       input logic [NPORT*NSEL-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected result.
    task automatic issue(input logic [2:0] v, input int a0, input int a1, input int a2,
                         input logic st, input logic clr,
                         input logic [31:0] e_en, input logic [31:0] e_p0,
                         input logic [31:0] e_p1, input logic [31:0] e_p2,
                         input logic e_conf, input int e_cnt);
        exp_t e;
        @(negedge clk);
        req_valid = v;
        req_addr  = {a2[4:0], a1[4:0], a0[4:0]};
        stall     = st;
        clr_cnt   = clr;
        e.wr_en     = e_en;
        e.wr_port   = {e_p2, e_p1, e_p0};
        e.out_valid = (e_en != 0);
        e.conflict  = e_conf;
        e.cnt       = e_cnt[CNT_W-1:0];
        exp_q.push_back(e);
    endtask

    // Monitor: after every rising edge, retire one queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                $display("txn %0d wr_en=%08h out_valid=%0b conflict=%0b cnt=%0d",
                         txn, wr_en, out_valid, conflict, conflict_cnt);
                chk("wr_en", {64'b0, wr_en}, {64'b0, e.wr_en});
                chk("wr_port", wr_port, e.wr_port);
                chk("out_valid", {95'b0, out_valid}, {95'b0, e.out_valid});
                chk("conflict", {95'b0, conflict}, {95'b0, e.conflict});
                chk("conflict_cnt", {94'b0, conflict_cnt}, {94'b0, e.cnt});
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, {64'b0, wr_en}, '0);
        chk({tag, "_wr_port"}, wr_port, '0);
        chk({tag, "_out_valid"}, {95'b0, out_valid}, '0);
        chk({tag, "_conflict"}, {95'b0, conflict}, '0);
        chk({tag, "_cnt"}, {94'b0, conflict_cnt}, '0);
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        stall     = 1'b0;
        clr_cnt   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        //      valid   a0 a1 a2 st clr  wr_en         p0            p1          p2          conf cnt
        issue(3'b000,  0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0,      0, 0);
        issue(3'b001,  7, 0, 0, 0, 0, 32'h80,       32'h80,       32'h0,      32'h0,      0, 0);
        issue(3'b011,  3, 3, 0, 0, 0, 32'h8,        32'h8,        32'h0,      32'h0,      1, 1);
        issue(3'b011, 31,31, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0,      0, 1);
        issue(3'b111,  0, 5,30, 0, 0, 32'h40000021, 32'h1,        32'h20,     32'h40000000,0, 1);
        issue(3'b110,  9, 9, 9, 0, 0, 32'h200,      32'h0,        32'h200,    32'h0,      1, 2);
        issue(3'b111, 31, 4, 4, 0, 0, 32'h10,       32'h0,        32'h10,     32'h0,      1, 3);
        issue(3'b111, 31,31, 6, 0, 0, 32'h40,       32'h0,        32'h0,      32'h40,     0, 3);
        issue(3'b001,  2, 0, 0, 0, 1, 32'h4,        32'h4,        32'h0,      32'h0,      0, 0);
        // stall: outputs and counter hold while colliding requests are presented
        issue(3'b011, 12,12, 0, 1, 0, 32'h4,        32'h4,        32'h0,      32'h0,      0, 0);
        issue(3'b111,  8, 8, 1, 1, 0, 32'h4,        32'h4,        32'h0,      32'h0,      0, 0);
        issue(3'b011, 12,12, 0, 1, 0, 32'h4,        32'h4,        32'h0,      32'h0,      0, 0);
        // saturation at 3
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 1);
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 2);
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 3);
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 3);
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 3);
        // clear during stall, then clear beating a simultaneous collision
        issue(3'b001,  6, 0, 0, 1, 1, 32'h2,        32'h2,        32'h0,      32'h0,      1, 0);
        issue(3'b011,  1, 1, 0, 0, 0, 32'h2,        32'h2,        32'h0,      32'h0,      1, 1);
        issue(3'b011,  1, 1, 0, 0, 1, 32'h2,        32'h2,        32'h0,      32'h0,      1, 0);
        issue(3'b001,  4, 0, 0, 0, 0, 32'h10,       32'h10,       32'h0,      32'h0,      0, 0);
        drain();

        // async reset between edges while wr_en = 0x10
        checks++;
        if (wr_en !== 32'h10) begin
            errors++;
            $display("FAIL pre_reset_wr_en got %0h expected 10", wr_en);
        end
        @(posedge clk);
        req_valid = 3'b001;
        req_addr  = 15'd4;
        #3;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        stall   = 1'b0;
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("reset_hold");

        @(negedge clk);
        reset_n = 1'b1;
        clr_cnt = 1'b0;
        issue(3'b001,  8, 0, 0, 0, 0, 32'h100,      32'h100,      32'h0,      32'h0,      0, 0);
        issue(3'b000,  8, 8, 0, 0, 0, 32'h0,        32'h0,        32'h0,      32'h0,      0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
